// File: rtl/rv32i_types.sv
// Shared RV32I types for the multicycle datapath.
// Also holds the data-memory controller FSM state encoding.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FINISH = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_byte_en.sv
// Byte-lane enables and alignment check for data accesses.
// Alignment trap logic present only with DMEM_MISALIGN_TRAP_EN.
module dmem_byte_en
  import rv32i_types::*;
(
  input  rv32i_opcode opcode,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [3:0]  byte_en,
  output logic        misaligned
);

  logic is_st;

  assign is_st = (opcode == op_store);

  always_comb begin
    byte_en = 4'b1111;
    if (is_st) begin
      unique case (1'b1)
        (funct3 == sb): byte_en = 4'b0001 << offset;
        (funct3 == sh): byte_en = 4'b0011 << offset;
        default:        byte_en = 4'b1111;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic is_ld;
  logic half;
  logic word;

  assign is_ld = (opcode == op_load);
  assign half  = (is_ld && (funct3 == lh || funct3 == lhu))
              || (is_st && funct3 == sh);
  assign word  = (is_ld && funct3 == lw)
              || (is_st && funct3 == sw);
  assign misaligned = (half & offset[0]) | (word & (|offset));
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: request/response handshake, MDR.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module dmem_ctrl
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  rv32i_opcode       opcode,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byte_enable,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mdr_out,
  output logic              done,
  output logic              misaligned
);

  dmem_state_t       state_q;
  dmem_state_t       state_d;
  logic              ld_q;
  logic              mis_q;
  logic [ADDR_W-1:2] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mdr_q;

  logic [3:0] be_c;
  logic       mis_c;
  logic       is_mem;
  logic       accept;

  dmem_byte_en u_be (
    .opcode     (opcode),
    .funct3     (funct3),
    .offset     (addr[1:0]),
    .byte_en    (be_c),
    .misaligned (mis_c)
  );

  assign is_mem = (opcode == op_load) || (opcode == op_store);
  assign accept = (state_q == IDLE) && start && is_mem;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = mis_c ? FINISH : ACCESS;
      ACCESS:  if (mem_resp) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ld_q    <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ld_q    <= (opcode == op_load);
        mis_q   <= mis_c;
        addr_q  <= addr[ADDR_W-1:2];
        be_q    <= be_c;
        wdata_q <= wdata;
      end
      if (state_q == ACCESS && mem_resp && ld_q)
        mdr_q <= mem_rdata;
    end
  end

  assign mem_read        = (state_q == ACCESS) && ld_q;
  assign mem_write       = (state_q == ACCESS) && !ld_q;
  assign mem_address     = {addr_q, 2'b00};
  assign mem_byte_enable = be_q;
  assign mem_wdata       = wdata_q;
  assign mdr_out         = mdr_q;
  assign done            = (state_q == FINISH);
  assign misaligned      = done && mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl.
// Honours DMEM_MISALIGN_TRAP_EN to match the build under test.
module tb_dmem_ctrl;
  import rv32i_types::*;

  logic        clk;
  logic        rst;
  logic        start;
  rv32i_opcode opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mdr_out;
  logic        done;
  logic        misaligned;

  typedef struct {
    logic        mis;
    logic [31:0] mdr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mdr;
  int          checks;
  int          errors;

  dmem_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .opcode          (opcode),
    .funct3          (funct3),
    .addr            (addr),
    .wdata           (wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mdr_out         (mdr_out),
    .done            (done),
    .misaligned      (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", done, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_misaligned", misaligned, e.mis);
        chk("sb_mdr", mdr_out, e.mdr);
      end
    end
  end

  task automatic run_acc(input rv32i_opcode op,
                         input logic [2:0]  f3,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [31:0] rd,
                         input int          lat,
                         input logic [3:0]  ebe,
                         input logic        emis,
                         input bit          poke);
    bit   is_ld;
    exp_t e;
    is_ld = (op == op_load);
    if (!emis && is_ld) model_mdr = rd;
    e.mis = emis;
    e.mdr = model_mdr;
    exp_q.push_back(e);
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    funct3 = f3;
    addr   = a;
    wdata  = wd;
    @(negedge clk);
    start = 1'b0;
    addr  = 32'hFFFF_FFFF;
    wdata = ~wd;
    if (!emis) begin
      for (int i = 0; i < lat; i++) begin
        chk("mem_read", mem_read, is_ld);
        chk("mem_write", mem_write, !is_ld);
        chk("mem_address", mem_address, {a[31:2], 2'b00});
        chk("byte_en", mem_byte_enable, ebe);
        if (!is_ld) chk("mem_wdata", mem_wdata, wd);
        chk("done_early", done, 1'b0);
        if (poke && i == 2) begin
          start  = 1'b1;
          opcode = op_load;
        end else begin
          start = 1'b0;
        end
        mem_resp  = (i == lat - 1);
        mem_rdata = (i == lat - 1) ? rd : $urandom;
        @(negedge clk);
      end
      mem_resp = 1'b0;
      start    = 1'b0;
    end
    chk("done", done, 1'b1);
    chk("misaligned", misaligned, emis);
    chk("fin_read", mem_read, 1'b0);
    chk("fin_write", mem_write, 1'b0);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("idle_read", mem_read, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] sh1_be;
    logic       mis_exp;
    checks    = 0;
    errors    = 0;
    model_mdr = '0;
    rst       = 1'b1;
    start     = 1'b0;
    opcode    = op_reg;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_read", mem_read, 1'b0);
    chk("rst_write", mem_write, 1'b0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_be", mem_byte_enable, 4'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_mdr", mdr_out, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_mis", misaligned, 1'b0);
    chk("rst_state", dut.state_q, IDLE);
    rst = 1'b0;

    run_acc(op_load, lw, 32'h100, 32'h0, 32'hDEADBEEF,
            3, 4'b1111, 1'b0, 1'b0);
    run_acc(op_store, sb, 32'h203, 32'hAB000000, 32'h0,
            1, 4'b1000, 1'b0, 1'b0);
    run_acc(op_store, sh, 32'h302, 32'hBEEF0000, 32'h0,
            10, 4'b1100, 1'b0, 1'b1);
    run_acc(op_store, sw, 32'h504, 32'h12345678, 32'h0,
            2, 4'b1111, 1'b0, 1'b0);
    run_acc(op_store, sb, 32'h600, 32'h000000EE, 32'h0,
            1, 4'b0001, 1'b0, 1'b0);
    run_acc(op_load, lbu, 32'h603, 32'h0, 32'h11223344,
            1, 4'b1111, 1'b0, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    mis_exp = 1'b1;
    sh1_be  = 4'b0000;
`else
    mis_exp = 1'b0;
    sh1_be  = 4'b0110;
`endif
    run_acc(op_store, sh, 32'h301, 32'h00CDAB00, 32'h0,
            2, sh1_be, mis_exp, 1'b0);
    run_acc(op_load, lw, 32'h101, 32'h0, 32'hCAFEF00D,
            1, 4'b1111, mis_exp, 1'b0);
    run_acc(op_load, lh, 32'h702, 32'h0, 32'h5A5A0000,
            2, 4'b1111, 1'b0, 1'b0);

    @(negedge clk);
    start  = 1'b1;
    opcode = op_load;
    funct3 = lw;
    addr   = 32'h400;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_read", mem_read, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_mdr = '0;
    chk("post_rst_read", mem_read, 1'b0);
    chk("post_rst_mdr", mdr_out, 32'h0);
    mem_resp  = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_resp_done", done, 1'b0);
      chk("late_resp_read", mem_read, 1'b0);
      @(negedge clk);
    end
    chk("late_resp_mdr", mdr_out, 32'h0);

    start  = 1'b1;
    opcode = op_reg;
    funct3 = 3'b000;
    addr   = 32'h800;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("opreg_read", mem_read, 1'b0);
      chk("opreg_write", mem_write, 1'b0);
      chk("opreg_done", done, 1'b0);
      chk("opreg_state", dut.state_q, IDLE);
      @(negedge clk);
    end
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
